// File: rtl/axb_rr_scheduler_if.sv
// Purpose: client-side bundle between four requesters and the shared y=a*x+b scheduler.
// Latency: none (wires only).
// Backpressure: req is held by a client until its gnt bit pulses; no other flow control.
interface axb_rr_scheduler_if #(
    parameter int W = 8
);
    logic [3:0]     req;
    logic [4*W-1:0] a_in;
    logic [4*W-1:0] x_in;
    logic [4*W-1:0] b_in;
    logic [3:0]     gnt;
    logic [2*W:0]   y;
    logic           y_valid;
    logic [1:0]     y_id;
    logic           busy;

    // Client side: raises requests and presents operands.
    modport master (
        output req, a_in, x_in, b_in,
        input  gnt, y, y_valid, y_id, busy
    );

    // Scheduler side: arbitrates and returns tagged results.
    modport slave (
        input  req, a_in, x_in, b_in,
        output gnt, y, y_valid, y_id, busy
    );
endinterface

// File: rtl/axb_rr_scheduler.sv
// Purpose: round-robin share of one multi-cycle y=a*x+b unit among four clients.
// Latency: MUL_CYCLES edges from grant to y_valid; grants spaced MUL_CYCLES+1 cycles.
// Backpressure: requests are ignored while busy and must be held until granted.
module axb_rr_scheduler #(
    parameter int W          = 8,
    parameter int MUL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    axb_rr_scheduler_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam int YW = 2 * W + 1;

    state_t         state_q;
    logic [1:0]     ptr_q;
    logic [1:0]     sel_q;
    logic [3:0]     cnt_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   b_q;
    logic [3:0]     gnt_q;
    logic [YW-1:0]  y_q;
    logic           y_valid_q;
    logic [1:0]     y_id_q;
    logic           busy_q;

    logic           win_found;
    logic [1:0]     win_idx;
    logic [YW-1:0]  y_d;

    // Round-robin winner: scan from ptr downward in offset so the smallest offset wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr_q + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 2'(i);
            end
        end
    end

    // Full-width multiply-add; operands are widened first so nothing is truncated.
    always_comb begin
        y_d = YW'(a_q) * YW'(x_q) + YW'(b_q);
    end

    // Scheduler FSM with registered grant, result and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            cnt_q     <= 4'd0;
            a_q       <= '0;
            x_q       <= '0;
            b_q       <= '0;
            gnt_q     <= 4'd0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_id_q    <= 2'd0;
            busy_q    <= 1'b0;
        end else begin
            gnt_q     <= 4'd0;
            y_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gnt_q   <= 4'b0001 << win_idx;
                        sel_q   <= win_idx;
                        a_q     <= bus.a_in[win_idx*W +: W];
                        x_q     <= bus.x_in[win_idx*W +: W];
                        b_q     <= bus.b_in[win_idx*W +: W];
                        cnt_q   <= 4'(MUL_CYCLES - 1);
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        y_q       <= y_d;
                        y_valid_q <= 1'b1;
                        y_id_q    <= sel_q;
                        ptr_q     <= sel_q + 2'd1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_id    = y_id_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_axb_rr_scheduler.sv
// Purpose: directed self-checking bench for the round-robin y=a*x+b scheduler.
// Latency: expects MUL_CYCLES=2 edges grant-to-result and 3-cycle grant spacing.
// Backpressure: clients hold req until the matching gnt pulse, then drop it.
module tb_axb_rr_scheduler;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    axb_rr_scheduler_if #(.W(W)) bus ();

    axb_rr_scheduler #(.W(W), .MUL_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Place one client's operands into the packed buses.
    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] x, input logic [W-1:0] b);
        bus.a_in[k*W +: W] = a;
        bus.x_in[k*W +: W] = x;
        bus.b_in[k*W +: W] = b;
    endtask

    // Wait for the next y_valid; lat is the number of edges waited, or -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.y_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.gnt, bus.y, bus.y_valid, bus.y_id, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got gnt=%b y=%0d vld=%b id=%0d busy=%b required all zero",
                     bus.gnt, bus.y, bus.y_valid, bus.y_id, bus.busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.a_in = $urandom;
        bus.x_in = $urandom;
        bus.b_in = $urandom;
        bus.req  = 4'($urandom_range(1, 15));
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: got busy=%b required 1", bus.busy);
        end
        #3;
        rst = 1'b1;
        bus.a_in = $urandom;
        bus.req  = 4'($urandom_range(0, 15));
        #1;
        checks++;
        if ({bus.gnt, bus.y, bus.y_valid, bus.y_id, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: got gnt=%b y=%0d vld=%b id=%0d busy=%b required all zero",
                     bus.gnt, bus.y, bus.y_valid, bus.y_id, bus.busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = 4'b0000;
    endtask

    task automatic test_single();
        int lat;
        set_ops(2, 8'd3, 8'd4, 8'd5);
        bus.req = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b busy=%b required 0100 1", bus.gnt, bus.busy);
        end
        bus.req = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_exec: got gnt=%b busy=%b vld=%b required 0000 1 0",
                     bus.gnt, bus.busy, bus.y_valid);
        end
        @(posedge clk); #1;
        lat = 2;
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y !== 17'd17 || bus.y_id !== 2'd2 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got vld=%b y=%0d id=%0d busy=%b after %0d edges required 1 17 2 0",
                     bus.y_valid, bus.y, bus.y_id, bus.busy, lat);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== 17'd17 || bus.y_id !== 2'd2) begin
            errors++;
            $display("FAIL single_hold: got vld=%b y=%0d id=%0d required 0 17 2", bus.y_valid, bus.y, bus.y_id);
        end
    endtask

    task automatic test_fairness();
        logic [16:0] exp_y [4];
        int k;
        exp_y[0] = 17'd12;
        exp_y[1] = 17'd17;
        exp_y[2] = 17'd24;
        exp_y[3] = 17'd33;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) set_ops(c, 8'(c + 1), 8'(c + 2), 8'(c + 10));
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            k = g % 4;
            @(posedge clk); #1;
            checks++;
            if (bus.gnt !== (4'b0001 << k)) begin
                errors++;
                $display("FAIL fair_grant%0d: got gnt=%b required %b", g, bus.gnt, 4'b0001 << k);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.gnt !== 4'b0000 || bus.y_valid !== 1'b0) begin
                errors++;
                $display("FAIL fair_gap%0d: got gnt=%b vld=%b required 0000 0", g, bus.gnt, bus.y_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.y_valid !== 1'b1 || bus.y_id !== 2'(k) || bus.y !== exp_y[k]) begin
                errors++;
                $display("FAIL fair_result%0d: got vld=%b id=%0d y=%0d required 1 %0d %0d",
                         g, bus.y_valid, bus.y_id, bus.y, k, exp_y[k]);
            end
            if (g == 4) bus.req = 4'b0000;
        end
    endtask

    task automatic test_wrap();
        int lat;
        set_ops(3, 8'd2, 8'd3, 8'd4);
        set_ops(0, 8'd5, 8'd5, 8'd5);
        bus.req = 4'b1000;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_pre_grant: got gnt=%b required 1000", bus.gnt);
        end
        wait_valid(lat);
        bus.req = 4'b1001;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_to_zero: got gnt=%b required 0001", bus.gnt);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 2 || bus.y !== 17'd30 || bus.y_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap_result0: got lat=%0d y=%0d id=%0d required 2 30 0", lat, bus.y, bus.y_id);
        end
        bus.req = 4'b1001;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_next3: got gnt=%b required 1000", bus.gnt);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 2 || bus.y !== 17'd10 || bus.y_id !== 2'd3) begin
            errors++;
            $display("FAIL wrap_result3: got lat=%0d y=%0d id=%0d required 2 10 3", lat, bus.y, bus.y_id);
        end
    endtask

    task automatic test_fullscale();
        int lat;
        set_ops(1, 8'd255, 8'd255, 8'd255);
        bus.req = 4'b0010;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL full_grant: got gnt=%b required 0010", bus.gnt);
        end
        bus.a_in = '0;
        bus.x_in = '1;
        bus.b_in = '0;
        wait_valid(lat);
        checks++;
        if (lat !== 2 || bus.y !== 17'd65280 || bus.y_id !== 2'd1) begin
            errors++;
            $display("FAIL full_result: got lat=%0d y=%0d id=%0d required 2 65280 1", lat, bus.y, bus.y_id);
        end
    endtask

    task automatic test_abort();
        int lat;
        int stray;
        set_ops(3, 8'd9, 8'd9, 8'd9);
        bus.req = 4'b1000;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL abort_grant: got gnt=%b required 1000", bus.gnt);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.y !== 17'd0 || bus.y_id !== 2'd0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b y=%0d id=%0d required 0 0 0", bus.busy, bus.y, bus.y_id);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.y_valid === 1'b1) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d y_valid pulses required 0", stray);
        end
        set_ops(1, 8'd6, 8'd7, 8'd8);
        bus.req = 4'b0010;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL abort_regrant: got gnt=%b required 0010", bus.gnt);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 2 || bus.y !== 17'd50 || bus.y_id !== 2'd1) begin
            errors++;
            $display("FAIL abort_result: got lat=%0d y=%0d id=%0d required 2 50 1", lat, bus.y, bus.y_id);
        end
        // ptr is now 2; abort a client-2 operation so only a pointer reset yields client 0 next.
        set_ops(0, 8'd1, 8'd1, 8'd1);
        bus.req = 4'b0100;
        @(posedge clk); #4;
        bus.req = 4'b0000;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #3;
        bus.req = 4'b1001;
        @(posedge clk); #1;
        bus.req = 4'b0000;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL abort_ptr_reset: got gnt=%b required 0001", bus.gnt);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 2 || bus.y !== 17'd2 || bus.y_id !== 2'd0) begin
            errors++;
            $display("FAIL abort_ptr_result: got lat=%0d y=%0d id=%0d required 2 2 0", lat, bus.y, bus.y_id);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.a_in = '0;
        bus.x_in = '0;
        bus.b_in = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_fullscale();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
